// File: rtl/fetch_unit_pkg.sv
// Shared constants and fetch FSM state encoding for the instruction-fetch stage.
package fetch_unit_pkg;

   localparam int          FETCH_XLEN = 32;
   localparam logic [31:0] FETCH_NOP  = 32'h00000033;  // add x0,x0,x0

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      ISSUE = 3'd1,
      WAIT  = 3'd2,
      HOLD  = 3'd3,
      DROP  = 3'd4
   } fetch_state_e;

endpackage

// File: rtl/fetch_unit_ifid_reg.sv
// IF/ID pipeline register: flush beats hold, hold beats load, otherwise a bubble.
module fetch_unit_ifid_reg #(
   parameter int          XLEN     = 32,
   parameter logic [31:0] NOP_INST = 32'h00000033
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            flush_i,
   input  logic            hold_i,
   input  logic            load_i,
   input  logic [XLEN-1:0] pc_i,
   input  logic [31:0]     inst_i,
   output logic            valid_o,
   output logic [XLEN-1:0] pc_o,
   output logic [XLEN-1:0] pc_plus4_o,
   output logic [31:0]     inst_o
);

   logic            valid_q;
   logic [XLEN-1:0] pc_q;
   logic [XLEN-1:0] pc_plus4_q;
   logic [31:0]     inst_q;

   // Bubbles and flushes leave the PC fields alone; only valid/inst are cleared.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         valid_q    <= 1'b0;
         pc_q       <= '0;
         pc_plus4_q <= XLEN'(4);
         inst_q     <= NOP_INST;
      end else if (flush_i || (!hold_i && !load_i)) begin
         valid_q <= 1'b0;
         inst_q  <= NOP_INST;
      end else if (!hold_i) begin
         valid_q    <= 1'b1;
         pc_q       <= pc_i;
         pc_plus4_q <= pc_i + XLEN'(4);
         inst_q     <= inst_i;
      end
   end

   assign valid_o    = valid_q;
   assign pc_o       = pc_q;
   assign pc_plus4_o = pc_plus4_q;
   assign inst_o     = inst_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: one imem request per instruction, 1-entry stall buffer,
// next-PC mux feeding the external PC register, redirect flush with late-response drop.
module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter int          XLEN     = FETCH_XLEN,
   parameter logic [31:0] NOP_INST = FETCH_NOP
) (
   input  logic            PC_clk,
   input  logic            rst,
   input  logic [XLEN-1:0] pc_q,
   output logic            pc_load,
   output logic [XLEN-1:0] pc_next,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   input  logic            imem_ready,
   input  logic [31:0]     imem_rdata,
   input  logic            redirect,
   input  logic [XLEN-1:0] redirect_target,
   input  logic            stall,
   output logic            ifid_valid,
   output logic [XLEN-1:0] ifid_pc,
   output logic [XLEN-1:0] ifid_pc_plus4,
   output logic [31:0]     ifid_inst
);

   fetch_state_e    state_q, state_d;
   logic [XLEN-1:0] addr_q, addr_d;
   logic [XLEN-1:0] buf_addr_q, buf_addr_d;
   logic [31:0]     buf_inst_q, buf_inst_d;
   logic            redir;
   logic            ifid_load;
   logic [XLEN-1:0] ifid_pc_d;
   logic [31:0]     ifid_inst_d;

   assign redir     = redirect && (state_q != IDLE);
   assign imem_req  = (state_q == WAIT) || (state_q == DROP);
   assign imem_addr = addr_q;

   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      buf_addr_d  = buf_addr_q;
      buf_inst_d  = buf_inst_q;
      pc_load     = 1'b0;
      pc_next     = addr_q + XLEN'(4);
      ifid_load   = 1'b0;
      ifid_pc_d   = addr_q;
      ifid_inst_d = imem_rdata;
      if (redir) begin
         // An outstanding request still owes a response; park in DROP to swallow it.
         pc_load    = 1'b1;
         pc_next    = redirect_target & ~XLEN'(3);
         buf_addr_d = '0;
         buf_inst_d = '0;
         state_d    = (imem_req && !imem_ready) ? DROP : ISSUE;
      end else begin
         case (state_q)
            IDLE:  state_d = ISSUE;
            ISSUE: begin
               addr_d  = pc_q & ~XLEN'(3);
               state_d = WAIT;
            end
            WAIT: begin
               if (imem_ready) begin
                  pc_load = 1'b1;
                  if (stall) begin
                     buf_addr_d = addr_q;
                     buf_inst_d = imem_rdata;
                     state_d    = HOLD;
                  end else begin
                     ifid_load = 1'b1;
                     state_d   = ISSUE;
                  end
               end
            end
            HOLD: begin
               if (!stall) begin
                  ifid_load   = 1'b1;
                  ifid_pc_d   = buf_addr_q;
                  ifid_inst_d = buf_inst_q;
                  state_d     = ISSUE;
               end
            end
            DROP:    if (imem_ready) state_d = ISSUE;
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge PC_clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         addr_q     <= '0;
         buf_addr_q <= '0;
         buf_inst_q <= '0;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         buf_addr_q <= buf_addr_d;
         buf_inst_q <= buf_inst_d;
      end
   end

   fetch_unit_ifid_reg #(
      .XLEN     (XLEN),
      .NOP_INST (NOP_INST)
   ) u_ifid (
      .clk_i      (PC_clk),
      .rst_i      (rst),
      .flush_i    (redir),
      .hold_i     (stall),
      .load_i     (ifid_load),
      .pc_i       (ifid_pc_d),
      .inst_i     (ifid_inst_d),
      .valid_o    (ifid_valid),
      .pc_o       (ifid_pc),
      .pc_plus4_o (ifid_pc_plus4),
      .inst_o     (ifid_inst)
   );

endmodule

// File: tb/tb_fetch_unit.sv
// Directed + random bench for fetch_unit; transaction-level model of fetch order,
// delivered instructions and PC register contents.
module tb_fetch_unit;

   localparam logic [31:0] NOP = 32'h00000033;

   logic        PC_clk = 1'b0;
   logic        rst;
   logic [31:0] pc_q;
   logic        pc_load;
   logic [31:0] pc_next;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready;
   logic [31:0] imem_rdata;
   logic        redirect;
   logic [31:0] redirect_target;
   logic        stall;
   logic        ifid_valid;
   logic [31:0] ifid_pc;
   logic [31:0] ifid_pc_plus4;
   logic [31:0] ifid_inst;

   int checks = 0;
   int errors = 0;

   // model state
   logic [31:0] exp_pc;
   logic        drop_pend;
   int          wcnt;
   int          lat;
   logic [31:0] q_pc[$];
   logic [31:0] q_inst[$];
   int          consumed;
   int          n_wait;
   int          n_wait_vld;
   // per-cycle samples
   logic        x_fer;
   logic        x_load;
   logic [31:0] x_next;
   logic [31:0] x_addr;

   fetch_unit dut (
      .PC_clk          (PC_clk),
      .rst             (rst),
      .pc_q            (pc_q),
      .pc_load         (pc_load),
      .pc_next         (pc_next),
      .imem_req        (imem_req),
      .imem_addr       (imem_addr),
      .imem_ready      (imem_ready),
      .imem_rdata      (imem_rdata),
      .redirect        (redirect),
      .redirect_target (redirect_target),
      .stall           (stall),
      .ifid_valid      (ifid_valid),
      .ifid_pc         (ifid_pc),
      .ifid_pc_plus4   (ifid_pc_plus4),
      .ifid_inst       (ifid_inst)
   );

   always #5 PC_clk = ~PC_clk;

   function automatic logic [31:0] memword(input logic [31:0] a);
      if (a == 32'h0) return 32'h00500093;
      return (a * 32'h9E3779B1) ^ 32'h00000013;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic check_reset_outs(input string tag);
      chk({tag, "_req"},   {31'b0, imem_req},   32'd0);
      chk({tag, "_addr"},  imem_addr,           32'd0);
      chk({tag, "_load"},  {31'b0, pc_load},    32'd0);
      chk({tag, "_valid"}, {31'b0, ifid_valid}, 32'd0);
      chk({tag, "_pc"},    ifid_pc,             32'd0);
      chk({tag, "_pc4"},   ifid_pc_plus4,       32'd4);
      chk({tag, "_inst"},  ifid_inst,           NOP);
   endtask

   task automatic model_reset();
      pc_q      = 32'h0;
      exp_pc    = 32'h0;
      drop_pend = 1'b0;
      wcnt      = 0;
      q_pc.delete();
      q_inst.delete();
   endtask

   task automatic do_reset(input string tag);
      rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_target = 32'h0;
      imem_ready = 1'b0; imem_rdata = 32'h0;
      model_reset();
      repeat (2) @(posedge PC_clk);
      #1 check_reset_outs(tag);
      @(negedge PC_clk);
      rst = 1'b0;
   endtask

   // One clock: drive memory, check against the model, advance model and PC register.
   task automatic cyc();
      logic exp_load;
      logic redir_now;
      @(negedge PC_clk);
      imem_ready = imem_req && (wcnt >= lat);
      imem_rdata = imem_ready ? memword(imem_addr) : $urandom;
      #1;
      redir_now = redirect;
      x_fer  = imem_req & imem_ready;
      x_load = pc_load;
      x_next = pc_next;
      x_addr = imem_addr;
      if (imem_req && !imem_ready) begin
         n_wait++;
         if (ifid_valid) n_wait_vld++;
      end
      chk("pc_q", pc_q, exp_pc);
      if (imem_req && !drop_pend) chk("imem_addr", imem_addr, exp_pc);
      exp_load = redir_now || (x_fer && !drop_pend);
      chk("pc_load", {31'b0, pc_load}, {31'b0, exp_load});
      if (exp_load)
         chk("pc_next", pc_next, redir_now ? (redirect_target & ~32'h3) : exp_pc + 32'd4);
      if (ifid_valid) begin
         if (q_pc.size() == 0) chk("ifid_valid_unexpected", {31'b0, ifid_valid}, 32'd0);
         else begin
            chk("ifid_pc",    ifid_pc,       q_pc[0]);
            chk("ifid_pc4",   ifid_pc_plus4, q_pc[0] + 32'd4);
            chk("ifid_inst",  ifid_inst,     q_inst[0]);
         end
      end else chk("ifid_bubble_inst", ifid_inst, NOP);
      if (ifid_valid && !stall && !redir_now && q_pc.size() > 0) begin
         void'(q_pc.pop_front());
         void'(q_inst.pop_front());
         consumed++;
      end
      if (redir_now) begin
         q_pc.delete();
         q_inst.delete();
         exp_pc    = redirect_target & ~32'h3;
         drop_pend = imem_req && !imem_ready;
      end else if (x_fer) begin
         if (drop_pend) drop_pend = 1'b0;
         else begin
            q_pc.push_back(exp_pc);
            q_inst.push_back(imem_rdata);
            exp_pc = exp_pc + 32'd4;
         end
      end
      if (x_fer) wcnt = 0;
      else if (imem_req) wcnt++;
      @(posedge PC_clk);
      #1;
      if (x_load) pc_q = x_next;
   endtask

   task automatic run_until_xfer(input string tag, input int max);
      int n = 0;
      n_wait = 0;
      n_wait_vld = 0;
      do begin
         cyc();
         n++;
      end while (!x_fer && n < max);
      chk({tag, "_xfer_seen"}, {31'b0, x_fer}, 32'd1);
   endtask

   initial begin
      lat = 0;
      consumed = 0;

      // 1: basic fetch at 0
      do_reset("rst0");
      lat = 1;
      run_until_xfer("t1", 10);
      chk("t1_load",  {31'b0, x_load}, 32'd1);
      chk("t1_next",  x_next,          32'h4);
      chk("t1_valid", {31'b0, ifid_valid}, 32'd1);
      chk("t1_pc",    ifid_pc,         32'h0);
      chk("t1_pc4",   ifid_pc_plus4,   32'h4);
      chk("t1_inst",  ifid_inst,       32'h00500093);

      // 2: four-cycle memory latency
      lat = 4;
      run_until_xfer("t2", 20);
      chk("t2_waits",     n_wait,     32'd4);
      chk("t2_wait_vld",  n_wait_vld, 32'd0);
      chk("t2_addr",      x_addr,     32'h4);

      // 3: stall when the response arrives
      stall = 1'b1;
      lat = 1;
      run_until_xfer("t3", 10);
      chk("t3_hold_pc",    ifid_pc,              32'h4);
      chk("t3_hold_valid", {31'b0, ifid_valid},  32'd1);
      cyc();
      cyc();
      chk("t3_hold_req", {31'b0, imem_req}, 32'd0);
      chk("t3_pcq",      pc_q,              32'hC);
      chk("t3_still_pc", ifid_pc,           32'h4);
      stall = 1'b0;
      cyc();
      chk("t3_pc",   ifid_pc,   32'h8);
      chk("t3_inst", ifid_inst, memword(32'h8));

      // 4: redirect while waiting, late response dropped
      lat = 3;
      cyc();
      chk("t4_in_wait", {31'b0, imem_req}, 32'd1);
      redirect = 1'b1;
      redirect_target = 32'h103;
      cyc();
      redirect = 1'b0;
      chk("t4_load",  {31'b0, x_load}, 32'd1);
      chk("t4_next",  x_next,          32'h100);
      chk("t4_valid", {31'b0, ifid_valid}, 32'd0);
      chk("t4_drop_req", {31'b0, imem_req}, 32'd1);
      run_until_xfer("t4d", 10);
      chk("t4_drop_load", {31'b0, x_load}, 32'd0);
      run_until_xfer("t4", 10);
      chk("t4_addr", x_addr,  32'h100);
      chk("t4_pc",   ifid_pc, 32'h100);

      // 5: redirect + stall together in HOLD
      stall = 1'b1;
      lat = 0;
      run_until_xfer("t5", 10);
      cyc();
      redirect = 1'b1;
      redirect_target = 32'h200;
      cyc();
      redirect = 1'b0;
      chk("t5_valid", {31'b0, ifid_valid}, 32'd0);
      chk("t5_inst",  ifid_inst,           NOP);
      stall = 1'b0;
      run_until_xfer("t5b", 10);
      chk("t5_addr", x_addr,  32'h200);
      chk("t5_pc",   ifid_pc, 32'h200);

      // 6: wrap at top of address space, then reset mid-request
      redirect = 1'b1;
      redirect_target = 32'hFFFFFFFE;
      cyc();
      redirect = 1'b0;
      run_until_xfer("t6", 10);
      chk("t6_addr", x_addr,        32'hFFFFFFFC);
      chk("t6_next", x_next,        32'h0);
      chk("t6_pc",   ifid_pc,       32'hFFFFFFFC);
      chk("t6_pc4",  ifid_pc_plus4, 32'h0);
      lat = 6;
      cyc();
      cyc();
      chk("t6_in_wait", {31'b0, imem_req}, 32'd1);
      @(negedge PC_clk);
      #2 rst = 1'b1;
      #1 check_reset_outs("t6_rst");
      do_reset("rst1");

      // random traffic
      consumed = 0;
      lat = 1;
      for (int i = 0; i < 800; i++) begin
         stall = ($urandom_range(9) < 3);
         redirect = ($urandom_range(19) == 0);
         redirect_target = $urandom;
         if (x_fer) lat = $urandom_range(3);
         cyc();
      end
      stall = 1'b0;
      redirect = 1'b0;
      repeat (20) cyc();
      chk("rand_progress", {31'b0, consumed > 30}, 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
